// File: rtl/axis_multimode_pattern_generator_if.sv
// AXI4-Stream bus carrying the generator output: data, valid/ready, last and channel id.
interface axis_multimode_pattern_generator_if #(
    parameter int DATA_WIDTH = 24,
    parameter int ID_WIDTH   = 1
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [ID_WIDTH-1:0]   tid;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        output tid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        input  tid,
        output tready
    );
endinterface

// File: rtl/axis_multimode_pattern_generator.sv
// Multi-mode AXI4-Stream test-pattern source. A divided-rate tick starts a frame of
// NUM_CHANNELS beats (sample + channel index) from a ramp, triangle, constant or LFSR
// value generator. Ticks that arrive while a frame is still in flight are counted.
module axis_multimode_pattern_generator #(
    parameter int          DATA_WIDTH    = 24,
    parameter int          NUM_CHANNELS  = 2,
    parameter longint      COUNTER_START = 0,
    parameter longint      COUNTER_END   = 100,
    parameter longint      COUNTER_INCR  = 1,
    parameter int          DIVIDER       = 5,
    parameter logic [31:0] LFSR_SEED     = 32'h1
) (
    input  logic                                      m_axis_aclk,
    input  logic                                      m_axis_aresetn,
    input  logic                                      enable,
    input  logic [1:0]                                mode,
    axis_multimode_pattern_generator_if.master        m_axis,
    output logic [15:0]                               overrun_count
);

    localparam int ID_WIDTH  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int DIV_WIDTH = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam int VW        = DATA_WIDTH + 1;

    localparam logic [VW-1:0]        START_W   = VW'(COUNTER_START);
    localparam logic [VW-1:0]        END_W     = VW'(COUNTER_END);
    localparam logic [VW-1:0]        INCR_W    = VW'(COUNTER_INCR);
    localparam logic [DIV_WIDTH-1:0] DIV_LAST  = DIV_WIDTH'(DIVIDER - 1);
    localparam logic [ID_WIDTH-1:0]  LAST_CH   = ID_WIDTH'(NUM_CHANNELS - 1);
    localparam logic [31:0]          LFSR_POLY = 32'h80200003;

    // Reject parameter sets the value generator cannot represent.
    generate
        if (DATA_WIDTH < 8 || DATA_WIDTH > 32) begin : g_bad_data_width
            $error("DATA_WIDTH must be within 8..32");
        end
        if (NUM_CHANNELS < 1 || NUM_CHANNELS > 8) begin : g_bad_channels
            $error("NUM_CHANNELS must be within 1..8");
        end
        if (COUNTER_START < 0 || COUNTER_START > COUNTER_END ||
            COUNTER_END >= (longint'(1) << DATA_WIDTH)) begin : g_bad_bounds
            $error("need 0 <= COUNTER_START <= COUNTER_END < 2**DATA_WIDTH");
        end
        if (COUNTER_INCR < 1 || COUNTER_INCR >= (longint'(1) << DATA_WIDTH)) begin : g_bad_incr
            $error("COUNTER_INCR must be within 1..2**DATA_WIDTH-1");
        end
        if (DIVIDER < 1) begin : g_bad_divider
            $error("DIVIDER must be at least 1");
        end
        if (LFSR_SEED == 32'h0) begin : g_bad_seed
            $error("LFSR_SEED must be nonzero");
        end
    endgenerate

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [DIV_WIDTH-1:0]   div_cnt;
    logic                   tick;
    logic                   accept_tick;
    logic                   drop_tick;
    logic                   beat_done;
    logic                   frame_done;
    logic [ID_WIDTH-1:0]    next_tid;

    logic [VW-1:0]          value;
    logic                   dir_down;
    logic [31:0]            lfsr;
    logic [1:0]             last_mode;

    logic                   restart;
    logic [VW-1:0]          cur_value;
    logic                   cur_dir_down;
    logic [31:0]            cur_lfsr;
    logic [VW-1:0]          up_value;
    logic [VW-1:0]          down_value;
    logic                   up_fits;
    logic                   down_fits;
    logic [VW-1:0]          value_next;
    logic                   dir_next;
    logic [31:0]            lfsr_next;
    logic [DATA_WIDTH-1:0]  sample;

    assign tick     = enable && (div_cnt == DIV_LAST);
    assign next_tid = m_axis.tid + 1'b1;

    // Sample-rate divider; disabling holds it at zero so re-enable waits a full period.
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            div_cnt <= '0;
        end else if (!enable || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Frame state register.
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Frame sequencing: a tick starts a frame only when idle, otherwise it is dropped.
    always_comb begin
        state_next  = state;
        accept_tick = 1'b0;
        drop_tick   = 1'b0;
        beat_done   = 1'b0;
        frame_done  = 1'b0;
        case (state)
            IDLE: begin
                if (tick) begin
                    accept_tick = 1'b1;
                    state_next  = SEND;
                end
            end
            SEND: begin
                drop_tick = tick;
                beat_done = m_axis.tvalid && m_axis.tready;
                if (beat_done && m_axis.tlast) begin
                    frame_done = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered beat outputs; each beat carries the frame sample plus its channel index.
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            m_axis.tvalid <= 1'b0;
            m_axis.tdata  <= '0;
            m_axis.tlast  <= 1'b0;
            m_axis.tid    <= '0;
        end else if (accept_tick) begin
            m_axis.tvalid <= 1'b1;
            m_axis.tdata  <= sample;
            m_axis.tid    <= '0;
            m_axis.tlast  <= (LAST_CH == '0);
        end else if (frame_done) begin
            m_axis.tvalid <= 1'b0;
            m_axis.tlast  <= 1'b0;
            m_axis.tid    <= '0;
        end else if (beat_done) begin
            m_axis.tdata  <= m_axis.tdata + 1'b1;
            m_axis.tid    <= next_tid;
            m_axis.tlast  <= (next_tid == LAST_CH);
        end
    end

    // Value generator next state; a mode change restarts from START/seed and emits that.
    always_comb begin
        restart      = (mode != last_mode);
        cur_value    = restart ? START_W : value;
        cur_dir_down = restart ? 1'b0 : dir_down;
        cur_lfsr     = restart ? LFSR_SEED : lfsr;
        up_value     = cur_value + INCR_W;
        down_value   = cur_value - INCR_W;
        up_fits      = (up_value <= END_W);
        down_fits    = (cur_value >= (START_W + INCR_W));
        value_next   = cur_value;
        dir_next     = cur_dir_down;
        lfsr_next    = cur_lfsr;
        sample       = cur_value[DATA_WIDTH-1:0];
        case (mode)
            2'd0: begin
                value_next = up_fits ? up_value : START_W;
            end
            2'd1: begin
                if (!cur_dir_down) begin
                    if (up_fits) begin
                        value_next = up_value;
                    end else begin
                        dir_next   = 1'b1;
                        value_next = down_fits ? down_value : START_W;
                    end
                end else begin
                    if (down_fits) begin
                        value_next = down_value;
                    end else begin
                        dir_next   = 1'b0;
                        value_next = up_fits ? up_value : END_W;
                    end
                end
            end
            2'd2: begin
                value_next = START_W;
                sample     = START_W[DATA_WIDTH-1:0];
            end
            default: begin
                lfsr_next = cur_lfsr[0] ? ((cur_lfsr >> 1) ^ LFSR_POLY) : (cur_lfsr >> 1);
                sample    = cur_lfsr[DATA_WIDTH-1:0];
            end
        endcase
    end

    // Generator state only advances when a tick is accepted into a new frame.
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            value     <= START_W;
            dir_down  <= 1'b0;
            lfsr      <= LFSR_SEED;
            last_mode <= 2'd0;
        end else if (accept_tick) begin
            value     <= value_next;
            dir_down  <= dir_next;
            lfsr      <= lfsr_next;
            last_mode <= mode;
        end
    end

    // Saturating count of ticks lost because a frame was still being sent.
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            overrun_count <= 16'd0;
        end else if (drop_tick && (overrun_count != 16'hFFFF)) begin
            overrun_count <= overrun_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_axis_multimode_pattern_generator.sv
// Scoreboard bench for the multi-mode pattern generator (START=1, END=10, INCR=3, 2 channels, divide by 5).
module tb_axis_multimode_pattern_generator;

    localparam int DW  = 24;
    localparam int NC  = 2;
    localparam int IDW = 1;

    typedef struct packed {
        logic [DW-1:0]  data;
        logic [IDW-1:0] id;
        logic           last;
    } beat_t;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  mode   = 2'd0;
    logic [15:0] overrun_count;

    beat_t exp_q[$];
    int    total = 0;
    int    bad   = 0;

    axis_multimode_pattern_generator_if #(.DATA_WIDTH(DW), .ID_WIDTH(IDW)) axis_bus();

    axis_multimode_pattern_generator #(
        .DATA_WIDTH   (DW),
        .NUM_CHANNELS (NC),
        .COUNTER_START(1),
        .COUNTER_END  (10),
        .COUNTER_INCR (3),
        .DIVIDER      (5),
        .LFSR_SEED    (32'h1)
    ) dut (
        .m_axis_aclk   (clk),
        .m_axis_aresetn(rst_n),
        .enable        (enable),
        .mode          (mode),
        .m_axis        (axis_bus),
        .overrun_count (overrun_count)
    );

    // 10-unit clock.
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic en, input logic [1:0] md, input logic rdy);
        enable         = en;
        mode           = md;
        axis_bus.tready = rdy;
    endtask

    task automatic push_frame(input logic [DW-1:0] s);
        beat_t b;
        b.data = s;
        b.id   = 1'b0;
        b.last = 1'b0;
        exp_q.push_back(b);
        b.data = s + 24'd1;
        b.id   = 1'b1;
        b.last = 1'b1;
        exp_q.push_back(b);
    endtask

    task automatic wait_for_queue(input int n, input string name);
        int budget;
        budget = 600;
        while (exp_q.size() > n && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        check_output(name, 32'(exp_q.size() <= n), 32'd1);
    endtask

    task automatic wait_for_valid(input string name);
        int budget;
        budget = 50;
        @(negedge clk);
        while (!axis_bus.tvalid && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check_output(name, 32'(axis_bus.tvalid), 32'd1);
    endtask

    // Monitor: every handshake pops the next expected beat and compares it.
    always @(negedge clk) begin
        beat_t e;
        if (rst_n && axis_bus.tvalid && axis_bus.tready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_beat: got data 0x%0h tid %0d, expected no beat",
                         axis_bus.tdata, axis_bus.tid);
            end else begin
                e = exp_q.pop_front();
                check_output("beat_tdata", 32'(axis_bus.tdata), 32'(e.data));
                check_output("beat_tid", 32'(axis_bus.tid), 32'(e.id));
                check_output("beat_tlast", 32'(axis_bus.tlast), 32'(e.last));
            end
        end
    end

    initial begin
        int tail_beats;
        axis_bus.tready = 1'b1;

        // Asynchronous reset values
        #2 rst_n = 1'b0;
        #1;
        check_output("rst_tvalid", 32'(axis_bus.tvalid), 32'd0);
        check_output("rst_tdata", 32'(axis_bus.tdata), 32'd0);
        check_output("rst_tlast", 32'(axis_bus.tlast), 32'd0);
        check_output("rst_tid", 32'(axis_bus.tid), 32'd0);
        check_output("rst_overrun", 32'(overrun_count), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Ramp from reset, with first-tick timing
        push_frame(24'd1); push_frame(24'd4); push_frame(24'd7); push_frame(24'd10); push_frame(24'd1);
        @(posedge clk); #1;
        apply_stimulus(1'b1, 2'd0, 1'b1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_output("first_tick_early", 32'(axis_bus.tvalid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_output("first_tick", 32'(axis_bus.tvalid), 32'd1);
        @(posedge clk); #1;
        wait_for_queue(0, "ramp_done");
        check_output("ramp_overrun", 32'(overrun_count), 32'd0);

        // Triangle restarts from START going up
        apply_stimulus(1'b1, 2'd1, 1'b1);
        push_frame(24'd1); push_frame(24'd4); push_frame(24'd7); push_frame(24'd10);
        push_frame(24'd7); push_frame(24'd4); push_frame(24'd1); push_frame(24'd4);
        wait_for_queue(0, "triangle_done");

        // Ramp up to v=7, then mode switches restart the generator
        apply_stimulus(1'b1, 2'd0, 1'b1);
        push_frame(24'd1); push_frame(24'd4);
        wait_for_queue(0, "switch_ramp_done");
        apply_stimulus(1'b1, 2'd1, 1'b1);
        push_frame(24'd1); push_frame(24'd4);
        wait_for_queue(0, "switch_tri_done");
        apply_stimulus(1'b1, 2'd2, 1'b1);
        push_frame(24'd1); push_frame(24'd1); push_frame(24'd1);
        wait_for_queue(0, "constant_done");

        // LFSR restarts from the seed
        apply_stimulus(1'b1, 2'd3, 1'b1);
        push_frame(24'h000001); push_frame(24'h200003); push_frame(24'h300002); push_frame(24'h180001);
        wait_for_queue(0, "lfsr_done");

        // Back-pressure: ready low for 12 cycles from beat 0 of a new ramp frame
        apply_stimulus(1'b1, 2'd0, 1'b0);
        push_frame(24'd1); push_frame(24'd4);
        wait_for_valid("bp_first_valid");
        for (int i = 0; i < 12; i++) begin
            check_output("bp_hold_tvalid", 32'(axis_bus.tvalid), 32'd1);
            check_output("bp_hold_tdata", 32'(axis_bus.tdata), 32'd1);
            check_output("bp_hold_tid", 32'(axis_bus.tid), 32'd0);
            @(posedge clk); #1;
        end
        apply_stimulus(1'b1, 2'd0, 1'b1);
        wait_for_queue(0, "bp_done");
        check_output("bp_overrun", 32'(overrun_count), 32'd2);

        // Enable dropped right after beat 0: the frame finishes, nothing new starts
        push_frame(24'd7);
        wait_for_valid("en_first_valid");
        @(posedge clk); #1;
        apply_stimulus(1'b0, 2'd0, 1'b1);
        tail_beats = 0;
        repeat (10) begin
            @(negedge clk);
            if (axis_bus.tvalid) tail_beats++;
        end
        check_output("en_tail_beats", 32'(tail_beats), 32'd1);
        check_output("en_queue_empty", 32'(exp_q.size()), 32'd0);

        // Re-enable: first tick a full divider period later, value continues
        @(posedge clk); #1;
        push_frame(24'd10);
        apply_stimulus(1'b1, 2'd0, 1'b1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_output("reen_tick_early", 32'(axis_bus.tvalid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_output("reen_tick", 32'(axis_bus.tvalid), 32'd1);
        @(posedge clk); #1;
        wait_for_queue(0, "reen_done");

        // Reset in the middle of a frame aborts it immediately
        push_frame(24'd1);
        wait_for_queue(1, "rst_mid_beat0");
        #2 rst_n = 1'b0;
        #1;
        check_output("rst_mid_tvalid", 32'(axis_bus.tvalid), 32'd0);
        check_output("rst_mid_tdata", 32'(axis_bus.tdata), 32'd0);
        check_output("rst_mid_tid", 32'(axis_bus.tid), 32'd0);
        check_output("rst_mid_overrun", 32'(overrun_count), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        push_frame(24'd1); push_frame(24'd4);
        wait_for_queue(0, "post_reset_done");

        apply_stimulus(1'b0, 2'd0, 1'b1);
        repeat (20) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
